// File: rtl/barrel_pkg.sv
// barrel_pkg: shared width defaults, stage derivation and FSM state type for barrel_unshifter_seq
package barrel_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_STAGES = $clog2(DEF_WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_bits(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction
endpackage

// File: rtl/rotr_stage.sv
// rotr_stage: one combinational rotate-right stage by 2^cnt, reused every RUN cycle
// BARREL_LOGICAL_MODE_EN adds mode: 1 = logical shift right (zero fill), 0 = rotate
module rotr_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 2
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             enable,
`ifdef BARREL_LOGICAL_MODE_EN
    input  logic             mode,
`endif
    output logic [WIDTH-1:0] result
);
    logic [2*WIDTH-1:0] src;
    // the low half of the doubled word shifted right is the rotation (or zero-filled shift)
    always_comb begin
`ifdef BARREL_LOGICAL_MODE_EN
        src = mode ? {{WIDTH{1'b0}}, data} : {data, data};
`else
        src = {data, data};
`endif
        result = enable ? WIDTH'(src >> (32'd1 << cnt)) : data;
    end
endmodule

// File: rtl/barrel_unshifter_seq.sv
// barrel_unshifter_seq: sequential rotate-right of a by s, one bit of s per RUN cycle, fixed latency
// BARREL_LOGICAL_MODE_EN adds a mode input selecting logical shift instead of rotate
module barrel_unshifter_seq
    import barrel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef BARREL_LOGICAL_MODE_EN
    input  logic              mode,
`endif
    input  logic [WIDTH-1:0]  a,
    input  logic [STAGES-1:0] s,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  sh
);
    localparam int CNT_W = cnt_bits(STAGES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STAGES - 1);
    state_t state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_q, stage_out;
    logic [STAGES-1:0] s_q;
    logic accept, last;
`ifdef BARREL_LOGICAL_MODE_EN
    logic mode_q;
`endif
    assign accept = start && (state != RUN);
    assign last = (state == RUN) && (cnt == LAST);
    rotr_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
        .data(data_q),
        .cnt(cnt),
        .enable(s_q[cnt]),
`ifdef BARREL_LOGICAL_MODE_EN
        .mode(mode_q),
`endif
        .result(stage_out)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end
    // every RUN pass walks all stages so latency never depends on s
    always_comb begin
        next_state = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            data_q <= '0;
            s_q <= '0;
            sh <= '0;
`ifdef BARREL_LOGICAL_MODE_EN
            mode_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= '0;
            data_q <= a;
            s_q <= s;
`ifdef BARREL_LOGICAL_MODE_EN
            mode_q <= mode;
`endif
        end else if (state == RUN) begin
            data_q <= stage_out;
            cnt <= last ? '0 : cnt + CNT_W'(1);
            if (last) sh <= stage_out;
        end
    end
endmodule
